// File: rtl/ps2_kbd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_kbd_decoder
//  Purpose  : Turns the raw byte stream of a PS/2 keyboard receiver into
//             key events. The E0 (extended) and F0 (break) prefix bytes are
//             folded into each event, and the events are queued in a small
//             FIFO for a consumer. The block also tracks whether shift or
//             ctrl is held.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FIFO_DEPTH   event FIFO entries (power of two, 2..16)
//    TIMEOUT_CYC  idle cycles before an incomplete prefix is abandoned (>= 1)
//  Ports
//    clk           system clock, rising edge
//    reset         asynchronous reset, active low
//    rx_done_tick  one-cycle strobe: rx_data holds a new byte
//    rx_data       received byte
//    rd_en         pop the head event (ignored when empty)
//    ovf_clr       clear the sticky overflow flag
//    ev_valid      FIFO non-empty
//    ev_code       head event scan code (0 when empty)
//    ev_ext        head event had the E0 prefix (0 when empty)
//    ev_break      head event is a release (0 when empty)
//    overflow      sticky: an event was dropped on a full FIFO
//    shift_held    left or right shift pressed
//    ctrl_held     left or right ctrl pressed
// ============================================================================
module ps2_kbd_decoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       rd_en,
  input  logic       ovf_clr,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       overflow,
  output logic       shift_held,
  output logic       ctrl_held
);

  // --------------------------------------------------------------------------
  // Derived sizes
  // --------------------------------------------------------------------------
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(FIFO_DEPTH);
  localparam logic [TW-1:0]   TMR_LAST  = TW'(TIMEOUT_CYC - 1);

  // Protocol bytes
  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_BRK = 8'hF0;

  // Modifier scan codes (set 2)
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;

  // --------------------------------------------------------------------------
  // Prefix FSM states
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_E0     = 2'd1;
  localparam logic [1:0] ST_F0     = 2'd2;
  localparam logic [1:0] ST_E0F0   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;

  // Event produced this cycle (combinational, valid with w_push)
  logic       w_push;
  logic       w_push_ext;
  logic       w_push_brk;
  logic [7:0] w_push_code;

  // Bytes the keyboard sends outside of key events (self-test result,
  // ACK, resend, error codes). Only meaningful when no prefix is pending.
  logic w_noise;
  assign w_noise = (rx_data == 8'h00) || (rx_data == 8'hAA) ||
                   (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
                   (rx_data == 8'hFF);

  logic w_is_prefix;
  assign w_is_prefix = (rx_data == BYTE_EXT) || (rx_data == BYTE_BRK);

  // The prefix flags of the pushed event follow directly from the state the
  // terminating byte arrives in.
  assign w_push_ext  = (state_q == ST_E0) || (state_q == ST_E0F0);
  assign w_push_brk  = (state_q == ST_F0) || (state_q == ST_E0F0);
  assign w_push_code = rx_data;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    w_push  = 1'b0;

    if (rx_done_tick) begin
      // Any byte restarts the idle counter, including entry into a prefix.
      tmr_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == BYTE_EXT) begin
            state_d = ST_E0;
          end else if (rx_data == BYTE_BRK) begin
            state_d = ST_F0;
          end else if (!w_noise) begin
            w_push = 1'b1;
          end
        end
        ST_E0: begin
          if (rx_data == BYTE_BRK) begin
            state_d = ST_E0F0;
          end else if (rx_data != BYTE_EXT) begin
            w_push  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_F0, ST_E0F0: begin
          // Repeated prefix bytes are swallowed; an E0 arriving after F0
          // does not upgrade the sequence to extended.
          if (!w_is_prefix) begin
            w_push  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      // A stalled prefix is abandoned once TIMEOUT_CYC tick-free cycles have
      // elapsed; the counter holds the number already seen.
      if (tmr_q >= TMR_LAST) begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end else begin
        tmr_d = tmr_q + TW'(1);
      end
    end else begin
      tmr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Event FIFO
  // --------------------------------------------------------------------------
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == DEPTH_C);
  assign w_pop   = rd_en && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are AW bits wide and the depth is a power of two, so the
    // increment wraps modulo FIFO_DEPTH on its own.
    if (w_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({w_wr, w_pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // A drop wins over a coincident clear so the loss is never hidden.
  always_comb begin
    ovf_d = ovf_q;
    if (w_drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: its contents are masked until written.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= {w_push_ext, w_push_brk, w_push_code};
    end
  end

  logic [9:0] w_head;
  assign w_head = mem_q[rd_ptr_q];

  assign ev_valid = !w_empty;
  assign ev_code  = w_empty ? 8'h00 : w_head[7:0];
  assign ev_ext   = w_empty ? 1'b0  : w_head[9];
  assign ev_break = w_empty ? 1'b0  : w_head[8];
  assign overflow = ovf_q;

  // --------------------------------------------------------------------------
  // Modifier tracking: follows every decoded event, even dropped ones, so the
  // held state stays correct while the consumer is slow.
  // --------------------------------------------------------------------------
  logic lshift_q, lshift_d;
  logic rshift_q, rshift_d;
  logic lctrl_q,  lctrl_d;
  logic rctrl_q,  rctrl_d;
  logic shift_q,  shift_d;
  logic ctrl_q,   ctrl_d;

  always_comb begin
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    lctrl_d  = lctrl_q;
    rctrl_d  = rctrl_q;
    if (w_push) begin
      if (!w_push_ext && (w_push_code == CODE_LSHIFT)) begin
        lshift_d = !w_push_brk;
      end
      if (!w_push_ext && (w_push_code == CODE_RSHIFT)) begin
        rshift_d = !w_push_brk;
      end
      if (w_push_code == CODE_CTRL) begin
        if (w_push_ext) begin
          rctrl_d = !w_push_brk;
        end else begin
          lctrl_d = !w_push_brk;
        end
      end
    end
    // Summary outputs are taken from the next-state flags so they change on
    // the same edge as the individual flags, one cycle after the tick.
    shift_d = lshift_d || rshift_d;
    ctrl_d  = lctrl_d  || rctrl_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      lctrl_q  <= 1'b0;
      rctrl_q  <= 1'b0;
      shift_q  <= 1'b0;
      ctrl_q   <= 1'b0;
    end else begin
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      lctrl_q  <= lctrl_d;
      rctrl_q  <= rctrl_d;
      shift_q  <= shift_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign shift_held = shift_q;
  assign ctrl_held  = ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_kbd_decoder
//  Purpose  : Self-checking bench for ps2_kbd_decoder. A queue-based model
//             of the prefix rules, event FIFO, overflow flag and modifier
//             flags predicts the outputs every cycle; directed scenarios add
//             fixed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_decoder;

  localparam int DEPTH = 4;
  localparam int TO    = 20;

  logic       clk;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rd_en;
  logic       ovf_clr;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       overflow;
  logic       shift_held;
  logic       ctrl_held;

  ps2_kbd_decoder #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .rd_en       (rd_en),
    .ovf_clr     (ovf_clr),
    .ev_valid    (ev_valid),
    .ev_code     (ev_code),
    .ev_ext      (ev_ext),
    .ev_break    (ev_break),
    .overflow    (overflow),
    .shift_held  (shift_held),
    .ctrl_held   (ctrl_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid, ext, brk, code[7:0], overflow, shift, ctrl}
  wire [13:0] obs = {ev_valid, ev_ext, ev_break, ev_code, overflow, shift_held, ctrl_held};

  int vectors;
  int miscompares;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [9:0] mq[$];      // {ext, brk, code}
  bit m_e0, m_f0;         // pending prefixes
  int m_idle;
  bit m_ovf, m_ls, m_rs, m_lc, m_rc;

  function automatic logic [13:0] model_out();
    logic [9:0] h;
    h = (mq.size() != 0) ? mq[0] : 10'h0;
    return {(mq.size() != 0), h[9], h[8], h[7:0], m_ovf, (m_ls | m_rs), (m_lc | m_rc)};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_e0 = 0; m_f0 = 0; m_idle = 0;
    m_ovf = 0; m_ls = 0; m_rs = 0; m_lc = 0; m_rc = 0;
  endtask

  task automatic model_step(input bit tk, input logic [7:0] d, input bit rd, input bit clr);
    bit pop, push, drop, noise;
    logic [9:0] ev;
    int sz;
    sz = mq.size();
    pop = rd && (sz > 0);
    push = 0;
    ev = '0;
    if (tk) begin
      m_idle = 0;
      noise = (d == 8'h00) || (d == 8'hAA) || (d == 8'hFA) || (d == 8'hFE) || (d == 8'hFF);
      if (d == 8'hE0) begin
        if (!m_e0 && !m_f0) m_e0 = 1;
      end else if (d == 8'hF0) begin
        m_f0 = 1;
      end else if (!(m_e0 || m_f0) && noise) begin
        push = 0;
      end else begin
        ev = {m_e0, m_f0, d};
        push = 1;
        m_e0 = 0;
        m_f0 = 0;
      end
    end else if (m_e0 || m_f0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_e0 = 0; m_f0 = 0; m_idle = 0;
      end
    end
    drop = push && (sz == DEPTH) && !pop;
    if (pop) void'(mq.pop_front());
    if (push && !drop) mq.push_back(ev);
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (push) begin
      if (!ev[9] && ev[7:0] == 8'h12) m_ls = !ev[8];
      if (!ev[9] && ev[7:0] == 8'h59) m_rs = !ev[8];
      if (ev[7:0] == 8'h14) begin
        if (ev[9]) m_rc = !ev[8];
        else       m_lc = !ev[8];
      end
    end
  endtask

  // One clock cycle of stimulus; starts and ends at a falling edge.
  task automatic step(input bit tk, input logic [7:0] d, input bit rd, input bit clr);
    rx_done_tick = tk;
    rx_data      = tk ? d : 8'($urandom);
    rd_en        = rd;
    ovf_clr      = clr;
    @(posedge clk);
    model_step(tk, d, rd, clr);
    @(negedge clk);
    rx_done_tick = 1'b0;
    rd_en        = 1'b0;
    ovf_clr      = 1'b0;
    rx_data      = 8'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    step(1, 8'h12, 0, 0);
    step(1, 8'h33, 0, 0);
    step(1, 8'hE0, 0, 0);
    // Assert mid-cycle, away from any clock edge, to expose the async path.
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (obs !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected %h", obs, 14'h0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== model_out()) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", obs, model_out());
    end
  endtask

  task automatic test_basic();
    do_reset();
    step(1, 8'h1C, 0, 0);
    vectors++;
    if (obs !== {1'b1, 1'b0, 1'b0, 8'h1C, 3'b000}) begin
      miscompares++;
      $display("FAIL basic_make: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 8'h1C, 3'b000});
    end
    step(0, 8'h00, 1, 0);
    vectors++;
    if (obs !== 14'h0) begin
      miscompares++;
      $display("FAIL basic_pop: got %h expected %h", obs, 14'h0);
    end
  endtask

  task automatic test_prefix();
    do_reset();
    step(1, 8'hF0, 0, 0);
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL prefix_f0_no_event: got %b expected 0", ev_valid);
    end
    step(1, 8'h1C, 0, 0);
    vectors++;
    if (obs[13:3] !== {1'b1, 1'b0, 1'b1, 8'h1C}) begin
      miscompares++;
      $display("FAIL prefix_break: got %h expected %h", obs[13:3], {1'b1, 1'b0, 1'b1, 8'h1C});
    end
    step(0, 8'h00, 1, 0);
    step(1, 8'hE0, 0, 0);
    step(1, 8'hF0, 0, 0);
    step(1, 8'h75, 0, 0);
    vectors++;
    if (obs[13:3] !== {1'b1, 1'b1, 1'b1, 8'h75}) begin
      miscompares++;
      $display("FAIL prefix_ext_break: got %h expected %h", obs[13:3], {1'b1, 1'b1, 1'b1, 8'h75});
    end
    step(0, 8'h00, 1, 0);
    step(1, 8'hAA, 0, 0);
    step(1, 8'hFA, 0, 0);
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL prefix_noise_dropped: got %b expected 0", ev_valid);
    end
    // F0 followed by E0 stays a plain break.
    step(1, 8'hF0, 0, 0);
    step(1, 8'hE0, 0, 0);
    step(1, 8'h2B, 0, 0);
    vectors++;
    if (obs !== model_out()) begin
      miscompares++;
      $display("FAIL prefix_f0_e0: got %h expected %h", obs, model_out());
    end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    do_reset();
    for (int i = 0; i < 5; i++) step(1, codes[i], 0, 0);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ev_valid !== 1'b1 || ev_code !== codes[i]) begin
        miscompares++;
        $display("FAIL ovf_order[%0d]: got %b/%h expected 1/%h", i, ev_valid, ev_code, codes[i]);
      end
      step(0, 8'h00, 1, 0);
    end
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_drained: got %b expected 0", ev_valid);
    end
    step(0, 8'h00, 0, 1);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clr: got %b expected 0", overflow);
    end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] order [4];
    order = '{8'h1D, 8'h24, 8'h2D, 8'h1C};
    do_reset();
    step(1, 8'h15, 0, 0);
    step(1, 8'h1D, 0, 0);
    step(1, 8'h24, 0, 0);
    step(1, 8'h2D, 0, 0);
    step(1, 8'h1C, 1, 0);
    vectors++;
    if (overflow !== 1'b0 || obs !== model_out()) begin
      miscompares++;
      $display("FAIL full_pushpop: got %h expected %h", obs, model_out());
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ev_valid !== 1'b1 || ev_code !== order[i]) begin
        miscompares++;
        $display("FAIL full_order[%0d]: got %b/%h expected 1/%h", i, ev_valid, ev_code, order[i]);
      end
      step(0, 8'h00, 1, 0);
    end
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_count: got %b expected 0", ev_valid);
    end
  endtask

  task automatic test_empty_pushpop();
    do_reset();
    step(1, 8'h33, 1, 0);
    vectors++;
    if (obs[13:3] !== {1'b1, 1'b0, 1'b0, 8'h33}) begin
      miscompares++;
      $display("FAIL empty_pushpop: got %h expected %h", obs[13:3], {1'b1, 1'b0, 1'b0, 8'h33});
    end
  endtask

  task automatic test_ovf_coincide();
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 8'h40 + 8'(i), 0, 0);
    step(1, 8'h44, 0, 1);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_coincide: got %b expected 1", overflow);
    end
    step(0, 8'h00, 0, 1);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear_after: got %b expected 0", overflow);
    end
  endtask

  task automatic test_modifiers();
    do_reset();
    step(1, 8'h12, 0, 0);
    vectors++;
    if (shift_held !== 1'b1 || ctrl_held !== 1'b0) begin
      miscompares++;
      $display("FAIL mod_shift: got %b%b expected 10", shift_held, ctrl_held);
    end
    step(1, 8'hE0, 0, 0);
    step(1, 8'h14, 0, 0);
    vectors++;
    if (shift_held !== 1'b1 || ctrl_held !== 1'b1) begin
      miscompares++;
      $display("FAIL mod_ctrl: got %b%b expected 11", shift_held, ctrl_held);
    end
    step(1, 8'hF0, 0, 0);
    step(1, 8'h12, 0, 0);
    vectors++;
    if (shift_held !== 1'b0 || ctrl_held !== 1'b1) begin
      miscompares++;
      $display("FAIL mod_shift_rel: got %b%b expected 01", shift_held, ctrl_held);
    end
    // Modifier must still track while the FIFO is full and events drop.
    step(1, 8'h59, 0, 0);
    step(1, 8'h59, 0, 0);
    vectors++;
    if (shift_held !== 1'b1 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL mod_during_drop: got %b/%b expected 1/1", shift_held, overflow);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(1, 8'hE0, 0, 0);
    repeat (TO - 1) step(0, 8'h00, 0, 0);
    step(1, 8'h1C, 0, 0);
    vectors++;
    if (obs[13:3] !== {1'b1, 1'b1, 1'b0, 8'h1C}) begin
      miscompares++;
      $display("FAIL timeout_not_yet: got %h expected %h", obs[13:3], {1'b1, 1'b1, 1'b0, 8'h1C});
    end
    step(0, 8'h00, 1, 0);
    step(1, 8'hE0, 0, 0);
    repeat (TO) step(0, 8'h00, 0, 0);
    step(1, 8'h1C, 0, 0);
    vectors++;
    if (obs[13:3] !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
      miscompares++;
      $display("FAIL timeout_expired: got %h expected %h", obs[13:3], {1'b1, 1'b0, 1'b0, 8'h1C});
    end
  endtask

  task automatic test_reset_midprefix();
    do_reset();
    step(1, 8'hE0, 0, 0);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    step(1, 8'h1C, 0, 0);
    vectors++;
    if (obs[13:3] !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
      miscompares++;
      $display("FAIL reset_midprefix: got %h expected %h", obs[13:3], {1'b1, 1'b0, 1'b0, 8'h1C});
    end
    step(0, 8'h00, 1, 0);
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midprefix_only: got %b expected 0", ev_valid);
    end
  endtask

  task automatic test_random();
    logic [7:0] tbl [10];
    bit tk, rd, clr;
    logic [7:0] d;
    int idx;
    tbl = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'hAA, 8'hFA, 8'h00, 8'h1C, 8'h00};
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tk  = ($urandom_range(0, 2) == 0);
      idx = int'($urandom_range(0, 9));
      d   = (idx == 9) ? 8'($urandom) : tbl[idx];
      rd  = ($urandom_range(0, 3) == 0) || (n >= 1500 && $urandom_range(0, 1) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step(tk, d, rd, clr);
      vectors++;
      if (obs !== model_out()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h", n, obs, model_out());
      end
      if ($urandom_range(0, 99) == 0) begin
        repeat (TO + int'($urandom_range(0, 2)) - 1) step(0, 8'h00, 0, 0);
        vectors++;
        if (obs !== model_out()) begin
          miscompares++;
          $display("FAIL random_gap[%0d]: got %h expected %h", n, obs, model_out());
        end
      end
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    rd_en        = 1'b0;
    ovf_clr      = 1'b0;
    model_clear();
    @(negedge clk);

    test_reset();
    test_basic();
    test_prefix();
    test_overflow();
    test_full_pushpop();
    test_empty_pushpop();
    test_ovf_coincide();
    test_modifiers();
    test_timeout();
    test_reset_midprefix();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
